sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Parameters
REQ-001 Module SHALL have parameter STARVE_LIMIT, default 3, giving the number of consecutive port-1 arbitration losses after which port 1 wins the next arbitration.

Interface
REQ-002 Clk  input  1  single clock; all state changes on rising edge.
REQ-003 Reset_n  input  1  asynchronous, active-low reset.
REQ-004 P0_Req, P1_Req  input  1 each  access request, held high until the port's Ack.
REQ-005 P0_WE, P1_WE  input  1 each  1 = write, 0 = read; stable while Req is high.
REQ-006 P0_Addr, P1_Addr  input  20 each  word address; stable while Req is high.
REQ-007 P0_WData, P1_WData  input  16 each  write data; stable while Req is high.
REQ-008 P0_BE, P1_BE  input  2 each  byte enables; [1] = upper, [0] = lower; 1 = enabled.
REQ-009 P0_Ack, P1_Ack  output  1 each  one-cycle completion pulse.
REQ-010 P0_RData, P1_RData  output  16 each  read result, valid when Ack is high after a read; holds until that port's next read completes.
REQ-011 SRAM_ADDR  output  20  SRAM address.
REQ-012 SRAM_DQ  inout  16  SRAM data bus.
REQ-013 SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N  output  1 each  active-low SRAM controls.

Function
REQ-014 FSM states SHALL be IDLE, RD1, RD2, WR_SETUP, WR_PULSE, WR_HOLD and DONE; all SRAM outputs and Acks SHALL be registered.
REQ-015 In IDLE with no Req high, the FSM SHALL stay in IDLE with CE_N=OE_N=WE_N=UB_N=LB_N=1 and SRAM_DQ high-Z.
REQ-016 Arbitration (IDLE, any Req high) SHALL grant port 0 when P0_Req=1, unless P1_Req=1 and starve_cnt==STARVE_LIMIT, in which case port 1 is granted.
REQ-017 starve_cnt SHALL increment, saturating at STARVE_LIMIT, on each arbitration where P1_Req=1 and port 0 is granted.
REQ-018 starve_cnt SHALL clear to 0 on every port-1 grant.
REQ-019 On grant, the FSM SHALL latch the granted port's WE/Addr/WData/BE and a grant-owner bit.
REQ-020 On grant, the FSM SHALL move to RD1 if WE=0, or to WR_SETUP if WE=1.
REQ-021 RD1 and RD2 SHALL drive CE_N=0, OE_N=0, WE_N=1, UB_N=~BE[1], LB_N=~BE[0], with SRAM_DQ high-Z.
REQ-022 On the rising edge ending RD2, SRAM_DQ SHALL be captured into the owner's RData; disabled bytes SHALL capture 0.
REQ-023 WR_SETUP, WR_PULSE and WR_HOLD SHALL drive CE_N=0, OE_N=1, byte enables as for reads, and SRAM_DQ=WData.
REQ-024 WE_N SHALL be 0 only in WR_PULSE.
REQ-025 DONE SHALL pulse the owner's Ack for exactly one cycle, deassert all SRAM controls, and return to IDLE.
REQ-026 Latency SHALL be fixed: request sampled at edge k, read Ack high in cycle k+3 to k+4, write Ack high in cycle k+4 to k+5.
REQ-027 Latency SHALL be independent of the other port.
REQ-028 SRAM_DQ SHALL never be driven while OE_N=0.
REQ-029 At least one cycle with both undriven SHALL separate read and write phases; this is guaranteed by the DONE and IDLE states.
REQ-030 A requester SHALL deassert Req in the cycle after Ack unless it issues a new request; a Req still high in IDLE is treated as a new request.
REQ-031 Req dropped before Ack (protocol violation) SHALL NOT abort an access already granted.
REQ-032 P0_Ack and P1_Ack SHALL never be high in the same cycle.
REQ-033 BE=2'b00 SHALL still run the full sequence with UB_N=LB_N=1 and produce an Ack.

Reset
REQ-034 Reset_n=0 SHALL asynchronously force IDLE.
REQ-035 Reset_n=0 SHALL set CE_N=OE_N=WE_N=UB_N=LB_N=1, SRAM_ADDR=0 and SRAM_DQ high-Z.
REQ-036 Reset_n=0 SHALL set both Acks to 0, both RData to 0, starve_cnt=0 and the grant-owner bit to 0.
REQ-037 Reset asserted mid-access SHALL abort the access with no Ack; WE_N SHALL return to 1 immediately.
REQ-038 The first arbitration after reset release SHALL occur on the first rising edge with Reset_n=1.

Verification
REQ-039 Reset, then P1 write Addr=0x00010, WData=0xBEEF, BE=11 -> WE_N low exactly one cycle; P1_Ack at cycle k+4; memory word = 0xBEEF.
REQ-040 P1 read Addr=0x00010, BE=01 -> OE_N low for 2 cycles; P1_Ack at cycle k+3; P1_RData=0x00EF.
REQ-041 P0 and P1 read requests asserted in the same cycle, both held -> P0 served first; P1 Ack follows 4 cycles after P0 Ack; never simultaneous Acks.
REQ-042 P0_Req held continuously (back-to-back reads) with P1_Req high -> P1 granted on its 4th arbitration (STARVE_LIMIT=3); starve_cnt then 0.
REQ-043 Reset_n pulsed low during WR_PULSE -> WE_N=1 and DQ high-Z immediately; no Ack; next request after release completes normally.
REQ-044 Bus monitor over all tests -> no cycle with SRAM_DQ driven while OE_N=0; no X on control outputs after reset.

Source files
------------

// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter in front of an async 16-bit SRAM.
// Fixed-latency read/write sequencing with port-1 starvation guard.
module sram_arbiter #(
  parameter int STARVE_LIMIT = 3
) (
  input  logic        Clk,
  input  logic        Reset_n,
  input  logic        P0_Req,
  input  logic        P0_WE,
  input  logic [19:0] P0_Addr,
  input  logic [15:0] P0_WData,
  input  logic [1:0]  P0_BE,
  output logic        P0_Ack,
  output logic [15:0] P0_RData,
  input  logic        P1_Req,
  input  logic        P1_WE,
  input  logic [19:0] P1_Addr,
  input  logic [15:0] P1_WData,
  input  logic [1:0]  P1_BE,
  output logic        P1_Ack,
  output logic [15:0] P1_RData,
  output logic [19:0] SRAM_ADDR,
  inout  wire  [15:0] SRAM_DQ,
  output logic        SRAM_CE_N,
  output logic        SRAM_UB_N,
  output logic        SRAM_LB_N,
  output logic        SRAM_OE_N,
  output logic        SRAM_WE_N
);

  localparam int CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  typedef enum logic [2:0] {
    IDLE,
    RD1,
    RD2,
    WR_SETUP,
    WR_PULSE,
    WR_HOLD,
    DONE
  } state_e;

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [19:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [1:0]    be_q, be_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ce_n_q, ce_n_d;
  logic          oe_n_q, oe_n_d;
  logic          we_n_q, we_n_d;
  logic          ub_n_q, ub_n_d;
  logic          lb_n_q, lb_n_d;
  logic          dq_oe_q, dq_oe_d;
  logic          ack0_q, ack0_d;
  logic          ack1_q, ack1_d;
  logic [15:0]   rdata0_q, rdata0_d;
  logic [15:0]   rdata1_q, rdata1_d;
  logic          gnt1;
  logic [15:0]   cap;

  assign SRAM_ADDR = addr_q;
  assign SRAM_CE_N = ce_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_UB_N = ub_n_q;
  assign SRAM_LB_N = lb_n_q;
  assign SRAM_DQ   = dq_oe_q ? wdata_q : 16'hzzzz;
  assign P0_Ack    = ack0_q;
  assign P1_Ack    = ack1_q;
  assign P0_RData  = rdata0_q;
  assign P1_RData  = rdata1_q;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    cnt_d    = cnt_q;
    ce_n_d   = 1'b1;
    oe_n_d   = 1'b1;
    we_n_d   = 1'b1;
    ub_n_d   = 1'b1;
    lb_n_d   = 1'b1;
    dq_oe_d  = 1'b0;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    gnt1     = P1_Req && (!P0_Req || cnt_q == LIM);
    cap      = SRAM_DQ & {{8{be_q[1]}}, {8{be_q[0]}}};
    unique case (state_q)
      IDLE: begin
        if (P0_Req || P1_Req) begin
          owner_d = gnt1;
          we_d    = gnt1 ? P1_WE    : P0_WE;
          addr_d  = gnt1 ? P1_Addr  : P0_Addr;
          wdata_d = gnt1 ? P1_WData : P0_WData;
          be_d    = gnt1 ? P1_BE    : P0_BE;
          if (gnt1) begin
            cnt_d = '0;
          end else if (P1_Req && cnt_q != LIM) begin
            cnt_d = cnt_q + CW'(1);
          end
          state_d = we_d ? WR_SETUP : RD1;
          ce_n_d  = 1'b0;
          oe_n_d  = we_d;
          ub_n_d  = ~be_d[1];
          lb_n_d  = ~be_d[0];
          dq_oe_d = we_d;
        end
      end
      RD1: begin
        state_d = RD2;
        ce_n_d  = 1'b0;
        oe_n_d  = 1'b0;
        ub_n_d  = ~be_q[1];
        lb_n_d  = ~be_q[0];
      end
      RD2: begin
        // bus has been stable for two cycles; capture and release
        state_d = DONE;
        if (owner_q) begin
          rdata1_d = cap;
          ack1_d   = 1'b1;
        end else begin
          rdata0_d = cap;
          ack0_d   = 1'b1;
        end
      end
      WR_SETUP: begin
        state_d = WR_PULSE;
        ce_n_d  = 1'b0;
        we_n_d  = 1'b0;
        ub_n_d  = ~be_q[1];
        lb_n_d  = ~be_q[0];
        dq_oe_d = 1'b1;
      end
      WR_PULSE: begin
        state_d = WR_HOLD;
        ce_n_d  = 1'b0;
        ub_n_d  = ~be_q[1];
        lb_n_d  = ~be_q[0];
        dq_oe_d = 1'b1;
      end
      WR_HOLD: begin
        state_d = DONE;
        ack0_d  = !owner_q;
        ack1_d  = owner_q;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= IDLE;
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      cnt_q    <= '0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      dq_oe_q  <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      cnt_q    <= cnt_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ub_n_q   <= ub_n_d;
      lb_n_q   <= lb_n_d;
      dq_oe_q  <= dq_oe_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter: directed table, corner sequences and random traffic
// against a transaction-level model of the two-port SRAM arbiter.
module tb_sram_arbiter;

  localparam int LIMIT = 3;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        P0_Req, P0_WE, P1_Req, P1_WE;
  logic [19:0] P0_Addr, P1_Addr;
  logic [15:0] P0_WData, P1_WData;
  logic [1:0]  P0_BE, P1_BE;
  logic        P0_Ack, P1_Ack;
  logic [15:0] P0_RData, P1_RData;
  logic [19:0] SRAM_ADDR;
  wire  [15:0] sram_dq;
  logic        SRAM_CE_N, SRAM_UB_N, SRAM_LB_N, SRAM_OE_N, SRAM_WE_N;

  int vecs = 0;
  int errs = 0;
  logic mem_init = 1'b1;
  logic [15:0] sram_mem [64];
  logic [15:0] ref_mem [64];

  typedef struct {
    bit          port;
    bit          we;
    logic [19:0] addr;
    logic [15:0] wdata;
    logic [1:0]  be;
    logic [15:0] exp_rdata;
    int          exp_lat;
  } vec_t;

  vec_t tbl [11];

  sram_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
    .Clk(Clk), .Reset_n(Reset_n),
    .P0_Req(P0_Req), .P0_WE(P0_WE), .P0_Addr(P0_Addr),
    .P0_WData(P0_WData), .P0_BE(P0_BE), .P0_Ack(P0_Ack), .P0_RData(P0_RData),
    .P1_Req(P1_Req), .P1_WE(P1_WE), .P1_Addr(P1_Addr),
    .P1_WData(P1_WData), .P1_BE(P1_BE), .P1_Ack(P1_Ack), .P1_RData(P1_RData),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_DQ(sram_dq),
    .SRAM_CE_N(SRAM_CE_N), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_OE_N(SRAM_OE_N), .SRAM_WE_N(SRAM_WE_N)
  );

  always #5 Clk = ~Clk;

  function automatic logic [15:0] pat(input int i);
    return {8'hA5, 8'(i)};
  endfunction

  // async SRAM device model
  assign sram_dq = (!SRAM_CE_N && !SRAM_OE_N && SRAM_WE_N) ?
                   sram_mem[SRAM_ADDR[5:0]] : 16'hzzzz;

  always @(posedge Clk) begin
    if (mem_init) begin
      for (int i = 0; i < 64; i++) sram_mem[i] <= pat(i);
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_UB_N) sram_mem[SRAM_ADDR[5:0]][15:8] <= sram_dq[15:8];
      if (!SRAM_LB_N) sram_mem[SRAM_ADDR[5:0]][7:0] <= sram_dq[7:0];
    end
  end

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(input bit p, input bit r, input bit we,
                       input logic [19:0] a, input logic [15:0] d,
                       input logic [1:0] be);
    if (!p) begin
      P0_Req = r; P0_WE = we; P0_Addr = a; P0_WData = d; P0_BE = be;
    end else begin
      P1_Req = r; P1_WE = we; P1_Addr = a; P1_WData = d; P1_BE = be;
    end
  endtask

  // one isolated access; latency counted in edges after the request edge
  task automatic single(input bit p, input bit we, input logic [19:0] a,
                        input logic [15:0] d, input logic [1:0] be,
                        output int lat, output logic [15:0] rd,
                        output int wel, output int oel);
    lat = 0; rd = '0; wel = 0; oel = 0;
    @(posedge Clk); #1;
    drive(p, 1'b1, we, a, d, be);
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge Clk); #1;
      if (!SRAM_WE_N) wel++;
      if (!SRAM_OE_N) oel++;
      if (p ? P1_Ack : P0_Ack) begin
        lat = c;
        rd = p ? P1_RData : P0_RData;
      end
    end
    drive(p, 1'b0, 1'b0, '0, '0, '0);
  endtask

  always @(negedge Clk) begin
    if (Reset_n) begin
      if (!SRAM_WE_N) check("mon_we_ctl", {SRAM_CE_N, SRAM_OE_N}, 2'b01);
      if (!SRAM_OE_N) check("mon_oe_we", SRAM_WE_N, 1'b1);
      if (!SRAM_OE_N && !SRAM_CE_N)
        check("mon_dq", sram_dq, sram_mem[SRAM_ADDR[5:0]]);
      check("mon_dual_ack", P0_Ack & P1_Ack, 1'b0);
      check("mon_x", $isunknown({SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N,
                                 SRAM_LB_N, P0_Ack, P1_Ack}), 1'b0);
    end
  end

  initial begin
    int lat, wel, oel, a0, a1, n0, p1n, first_p1, acks;
    int t, free_at, ack_t, starve;
    int runs [2];
    bit both, g1, own, m_rd, mwe;
    logic [15:0] rd, r0, r1, exp_rd, md;
    logic [19:0] ma;
    logic [1:0] mbe;

    tbl[0]  = '{1'b1, 1'b1, 20'h00010, 16'hBEEF, 2'b11, 16'h0000, 4};
    tbl[1]  = '{1'b1, 1'b0, 20'h00010, 16'h0000, 2'b01, 16'h00EF, 3};
    tbl[2]  = '{1'b1, 1'b0, 20'h00010, 16'h0000, 2'b10, 16'hBE00, 3};
    tbl[3]  = '{1'b0, 1'b1, 20'h00011, 16'h1234, 2'b01, 16'h0000, 4};
    tbl[4]  = '{1'b0, 1'b0, 20'h00011, 16'h0000, 2'b11, 16'hA534, 3};
    tbl[5]  = '{1'b0, 1'b1, 20'h00012, 16'hFFFF, 2'b00, 16'h0000, 4};
    tbl[6]  = '{1'b0, 1'b0, 20'h00012, 16'h0000, 2'b11, 16'hA512, 3};
    tbl[7]  = '{1'b1, 1'b0, 20'h00012, 16'h0000, 2'b00, 16'h0000, 3};
    tbl[8]  = '{1'b0, 1'b1, 20'h0003F, 16'hCD00, 2'b10, 16'h0000, 4};
    tbl[9]  = '{1'b1, 1'b0, 20'h0003F, 16'h0000, 2'b11, 16'hCD3F, 3};
    tbl[10] = '{1'b0, 1'b0, 20'h0003F, 16'h0000, 2'b01, 16'h003F, 3};

    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b0, 1'b1, 1'b0, 20'h00020, '0, 2'b11);
    repeat (3) @(posedge Clk);
    #1;
    mem_init = 1'b0;
    check("rst_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N},
          5'h1F);
    check("rst_addr", SRAM_ADDR, 20'h0);
    check("rst_acks", {P0_Ack, P1_Ack}, 2'b00);
    check("rst_rdata0", P0_RData, 16'h0);
    check("rst_rdata1", P1_RData, 16'h0);

    // request already pending at release: first edge arbitrates
    Reset_n = 1'b1;
    lat = 0; rd = '0;
    for (int c = 1; c <= 12 && lat == 0; c++) begin
      @(posedge Clk); #1;
      if (P0_Ack) begin lat = c; rd = P0_RData; end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    check("first_arb_lat", lat, 3);
    check("first_arb_rdata", rd, 16'hA520);

    for (int i = 0; i < 11; i++) begin
      single(tbl[i].port, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].be,
             lat, rd, wel, oel);
      check($sformatf("vec%0d_lat", i), lat, tbl[i].exp_lat);
      check($sformatf("vec%0d_we_low", i), wel, tbl[i].we ? 1 : 0);
      check($sformatf("vec%0d_oe_low", i), oel, tbl[i].we ? 0 : 2);
      if (!tbl[i].we) check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp_rdata);
      if (i == 0) check("mem_0x10", sram_mem[16], 16'hBEEF);
    end

    // simultaneous reads, both held
    @(posedge Clk); #1;
    drive(1'b0, 1'b1, 1'b0, 20'h00011, '0, 2'b11);
    drive(1'b1, 1'b1, 1'b0, 20'h0003F, '0, 2'b11);
    a0 = 0; a1 = 0; both = 0; r0 = '0; r1 = '0;
    for (int c = 1; c <= 20 && (a0 == 0 || a1 == 0); c++) begin
      @(posedge Clk); #1;
      if (P0_Ack && P1_Ack) both = 1'b1;
      if (P0_Ack && a0 == 0) begin
        a0 = c; r0 = P0_RData; drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
      end
      if (P1_Ack && a1 == 0) begin
        a1 = c; r1 = P1_RData; drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("sim_p0_lat", a0, 3);
    check("sim_p1_lat", a1, 7);
    check("sim_no_dual", both, 1'b0);
    check("sim_p0_rdata", r0, 16'hA534);
    check("sim_p1_rdata", r1, 16'hCD3F);

    // P0 back-to-back forever, P1 held: P1 wins every 4th arbitration
    @(posedge Clk); #1;
    drive(1'b0, 1'b1, 1'b0, 20'h00010, '0, 2'b11);
    drive(1'b1, 1'b1, 1'b0, 20'h00012, '0, 2'b11);
    n0 = 0; p1n = 0; first_p1 = 0; runs[0] = -1; runs[1] = -1; r1 = '0;
    for (int c = 1; c <= 80 && p1n < 2; c++) begin
      @(posedge Clk); #1;
      if (P0_Ack) n0++;
      if (P1_Ack) begin
        if (p1n == 0) begin first_p1 = c; r1 = P1_RData; end
        runs[p1n] = n0;
        n0 = 0;
        p1n++;
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    check("starve_p1_acks", p1n, 2);
    check("starve_first_p1", first_p1, 15);
    check("starve_run0", runs[0], 3);
    check("starve_run1", runs[1], 3);
    check("starve_p1_rdata", r1, 16'hA512);
    repeat (3) @(posedge Clk);

    // reset during the write strobe
    @(posedge Clk); #1;
    drive(1'b0, 1'b1, 1'b1, 20'h00020, 16'h5555, 2'b11);
    for (int c = 0; c < 10 && SRAM_WE_N; c++) begin
      @(posedge Clk); #1;
    end
    check("abort_saw_pulse", SRAM_WE_N, 1'b0);
    #2;
    Reset_n = 1'b0;
    #1;
    check("abort_ctl", {SRAM_CE_N, SRAM_OE_N, SRAM_WE_N, SRAM_UB_N, SRAM_LB_N},
          5'h1F);
    check("abort_addr", SRAM_ADDR, 20'h0);
    check("abort_rdata0", P0_RData, 16'h0);
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    acks = 0;
    repeat (2) begin
      @(posedge Clk);
      if (P0_Ack || P1_Ack) acks++;
    end
    @(posedge Clk); #1;
    Reset_n = 1'b1;
    repeat (6) begin
      @(posedge Clk); #1;
      if (P0_Ack || P1_Ack) acks++;
    end
    check("abort_no_ack", acks, 0);
    check("abort_no_write", sram_mem[32], 16'hA520);
    single(1'b0, 1'b1, 20'h00022, 16'h7777, 2'b11, lat, rd, wel, oel);
    check("post_rst_wr_lat", lat, 4);
    check("post_rst_mem", sram_mem[34], 16'h7777);
    single(1'b1, 1'b0, 20'h00021, '0, 2'b11, lat, rd, wel, oel);
    check("post_rst_rd_lat", lat, 3);
    check("post_rst_rdata", rd, 16'hA521);

    // random traffic against the transaction model
    repeat (3) @(posedge Clk);
    #1;
    mem_init = 1'b1;
    @(posedge Clk); #1;
    mem_init = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = pat(i);
    t = 0; free_at = 0; ack_t = -1; starve = 0;
    own = 1'b0; m_rd = 1'b0; exp_rd = '0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge Clk);
      t++;
      if (t >= free_at && (P0_Req || P1_Req)) begin
        g1 = P1_Req && (!P0_Req || starve == LIMIT);
        mwe = g1 ? P1_WE : P0_WE;
        ma  = g1 ? P1_Addr : P0_Addr;
        md  = g1 ? P1_WData : P0_WData;
        mbe = g1 ? P1_BE : P0_BE;
        if (g1) starve = 0;
        else if (P1_Req && starve < LIMIT) starve++;
        if (mwe) begin
          if (mbe[1]) ref_mem[ma[5:0]][15:8] = md[15:8];
          if (mbe[0]) ref_mem[ma[5:0]][7:0] = md[7:0];
        end else begin
          exp_rd = ref_mem[ma[5:0]] & {{8{mbe[1]}}, {8{mbe[0]}}};
        end
        own = g1;
        m_rd = !mwe;
        ack_t = t + (mwe ? 3 : 2);
        free_at = t + (mwe ? 5 : 4);
      end
      #1;
      check("rnd_ack0", P0_Ack, (t == ack_t) && !own);
      check("rnd_ack1", P1_Ack, (t == ack_t) && own);
      if (t == ack_t && m_rd)
        check("rnd_rdata", own ? P1_RData : P0_RData, exp_rd);
      if (P0_Ack) P0_Req = 1'b0;
      if (P1_Ack) P1_Req = 1'b0;
      if (!P0_Req) begin
        if ($urandom_range(0, 2) == 0)
          drive(1'b0, 1'b1, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 63)),
                16'($urandom), 2'($urandom_range(0, 3)));
      end else if ($urandom_range(0, 39) == 0) begin
        P0_Req = 1'b0;
      end
      if (!P1_Req) begin
        if ($urandom_range(0, 2) == 0)
          drive(1'b1, 1'b1, 1'($urandom_range(0, 1)), 20'($urandom_range(0, 63)),
                16'($urandom), 2'($urandom_range(0, 3)));
      end else if ($urandom_range(0, 39) == 0) begin
        P1_Req = 1'b0;
      end
    end
    drive(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive(1'b1, 1'b0, 1'b0, '0, '0, '0);
    repeat (6) @(posedge Clk);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
